msg_fetch_master: RTL and testbench
===================================

MSG_FETCH_MASTER -- requirements
Module: msg_fetch_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of message words and of bus data.
REQ-002 SHALL have parameter ADDR_CHANNEL, default 0, the byte address of the queue channel on the bus.
REQ-003 SHALL have parameter RESP_TIMEOUT, default 255, the maximum number of cycles to wait for a response after command accept.
REQ-004 Port clk  in  1  the single clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low; bus.MReset_n SHALL be driven from rst_n.
REQ-006 Port bus  Bus_if.master  -  OCP initiator to the queue's reader port: MCmd, MAddr, MData, MDataValid, MRespAccept driven; SCmdAccept, SResp, SData sampled.
REQ-007 Port enable  in  1  when high, the block may issue new reads.
REQ-008 Port out_data  out  DATA_WIDTH  the head word of the output buffer.
REQ-009 Port out_valid  out  1  the output buffer is non-empty.
REQ-010 Port out_ready  in  1  the consumer takes out_data when out_valid and out_ready are both high.
REQ-011 Port count  out  16  the number of words received; wraps from 0xFFFF to 0.
REQ-012 Port timeout_err  out  1  sticky flag, set when a response times out.

Function
REQ-013 FSM SHALL have states IDLE, CMD, RESP and ERR.
- IDLE: go to CMD when enable=1, timeout_err=0 and the output buffer has at least one free slot (occupancy < 2).
REQ-014 In CMD, the block SHALL drive MCmd=Bus::RD and MAddr=ADDR_CHANNEL and hold both stable until SCmdAccept=1.
- On accept: go to RESP.
- Bus::RD SHALL be asserted in no other state.
REQ-015 In all states other than CMD, MCmd SHALL be Bus::IDLE; MDataValid SHALL be 0 and MData SHALL be 0 at all times.
REQ-016 In RESP, MRespAccept SHALL be 1.
- On SResp==Bus::DVA: write SData into the output buffer, increment count, return to IDLE.
- The response may arrive at the earliest one cycle after accept.
REQ-017 The RESP wait counter SHALL clear on entry to RESP and increment each cycle with SResp==Bus::NULL.
- On reaching RESP_TIMEOUT: set timeout_err and go to ERR.
REQ-018 ERR SHALL be terminal until reset: no bus commands; out_valid/out_data continue to drain already-buffered words.
REQ-019 A read that stalls in CMD (queue empty, SCmdAccept=0) SHALL wait indefinitely; no timeout applies in CMD.
REQ-020 Deassertion of enable SHALL NOT abort CMD or RESP.
- A command already driven SHALL be held until accepted and its response collected.
REQ-021 The output buffer SHALL be a 2-entry FIFO with registered out_valid and out_data presenting the head entry with zero added latency.
- Simultaneous write and read when full or empty SHALL be handled without loss or duplication.
REQ-022 An FSM transition IDLE->CMD SHALL be made only if the free slot is guaranteed at response time; at most one read is outstanding.
REQ-023 Throughput: one word per 3 cycles minimum (IDLE, CMD, RESP), with no bubbles beyond that when the queue is non-empty and out_ready=1.
REQ-024 An SResp value other than NULL or DVA in RESP SHALL set timeout_err and go to ERR.

Reset
REQ-025 While rst_n=0:
- state=IDLE, MCmd=Bus::IDLE, MAddr=0, MRespAccept=0;
- buffer empty, out_valid=0, out_data=0;
- count=0, timeout_err=0, wait counter=0.
REQ-026 Reset asserted mid-CMD or mid-RESP SHALL immediately drop MCmd to IDLE; any in-flight response SHALL be discarded.

Structure
REQ-027 The Bus package SHALL provide the MCmd and SResp enumerations (IDLE, RD, WR; NULL, DVA, ...); the FSM state typedef SHALL be local to the module.
REQ-028 The 2-entry output buffer SHALL be a sub-module named skid_fifo2, parameterized by DATA_WIDTH.

Verification
REQ-029 Scenario (basic fetch):
- Stimulus: queue preloaded with 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003; enable=1; out_ready=1.
- Response: words appear in order on out_data; count=3; then MCmd holds RD with SCmdAccept=0.
REQ-030 Scenario (backpressure):
- Stimulus: queue holds 5 words; out_ready=0.
- Response: exactly 2 reads issued; out_valid=1 with head 1st word; after raising out_ready, all 5 delivered, no loss.
REQ-031 Scenario (timeout):
- Stimulus: a slave model accepts the RD but never returns DVA; RESP_TIMEOUT=8.
- Response: timeout_err=1 exactly 8 cycles after accept; no further MCmd=RD.
REQ-032 Scenario (enable drop):
- Stimulus: enable dropped in the same cycle CMD is entered on an empty queue.
- Response: RD held; after the writer pushes 0x1234, it is delivered and the FSM stays in IDLE.
REQ-033 Scenario (reset mid-RESP):
- Stimulus: rst_n pulsed low for 1 cycle during RESP.
- Response: MCmd=IDLE immediately; count=0, out_valid=0; normal fetch resumes after release.
REQ-034 Scenario (count wrap):
- Stimulus: count forced to 0xFFFF, then one word fetched.
- Response: count=0x0000.

Source files
------------

// File: rtl/Bus.sv
// Command and response encodings shared by initiators and targets on the queue bus.
package Bus;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    WR   = 3'b001,
    RD   = 3'b010
  } mcmd_e;

  typedef enum logic [1:0] {
    NULL = 2'b00,
    DVA  = 2'b01,
    FAIL = 2'b10,
    ERR  = 2'b11
  } sresp_e;

endpackage

// File: rtl/Bus_if.sv
// Point-to-point bus between a fetch master and the queue reader port.
interface Bus_if #(
  parameter int unsigned DataWidth = 32
) ();

  Bus::mcmd_e           MCmd;
  logic [31:0]          MAddr;
  logic [DataWidth-1:0] MData;
  logic                 MDataValid;
  logic                 MRespAccept;
  logic                 MReset_n;
  logic                 SCmdAccept;
  Bus::sresp_e          SResp;
  logic [DataWidth-1:0] SData;

  modport master (
    output MCmd, MAddr, MData, MDataValid, MRespAccept, MReset_n,
    input  SCmdAccept, SResp, SData
  );

  modport slave (
    input  MCmd, MAddr, MData, MDataValid, MRespAccept, MReset_n,
    output SCmdAccept, SResp, SData
  );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO whose head entry is presented directly from registers.
module skid_fifo2 #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  rd_ready_i
);

  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic                  head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
  logic                  pop;

  assign pop        = head_vld_q & rd_ready_i;
  assign full_o     = tail_vld_q;
  assign rd_valid_o = head_vld_q;
  assign rd_data_o  = head_q;

  // Apply the pop first, then let the write land in the first free slot, so a
  // simultaneous read and write never loses or repeats an entry.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    if (pop) begin
      head_d     = tail_q;
      head_vld_d = tail_vld_q;
      tail_vld_d = 1'b0;
    end
    if (wr_valid_i) begin
      if (!head_vld_d) begin
        head_d     = wr_data_i;
        head_vld_d = 1'b1;
      end else if (!tail_vld_d) begin
        tail_d     = wr_data_i;
        tail_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

endmodule

// File: rtl/msg_fetch_master.sv
// Reads words one at a time from a queue channel and buffers them for a
// ready/valid consumer; a missing or bad response latches an error state.
module msg_fetch_master #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_CHANNEL = 0,
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  Bus_if.master                 bus,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           count,
  output logic                  timeout_err
);

  localparam int unsigned WaitW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StResp, StErr} state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [15:0]      count_q, count_d;
  logic             err_q, err_d;
  logic             fifo_wr;
  logic             fifo_full;

  assign bus.MReset_n   = rst_n;
  assign bus.MData      = '0;
  assign bus.MDataValid = 1'b0;
  assign count          = count_q;
  assign timeout_err    = err_q;

  always_comb begin
    state_d         = state_q;
    wait_d          = wait_q;
    count_d         = count_q;
    err_d           = err_q;
    fifo_wr         = 1'b0;
    bus.MCmd        = Bus::IDLE;
    bus.MAddr       = '0;
    bus.MRespAccept = 1'b0;
    case (state_q)
      StIdle: begin
        // Only reads while idle never fill the buffer, so a free slot now is
        // still free when the single outstanding response returns.
        if (enable && !err_q && !fifo_full) state_d = StCmd;
      end
      StCmd: begin
        bus.MCmd  = Bus::RD;
        bus.MAddr = ADDR_CHANNEL;
        if (bus.SCmdAccept) begin
          state_d = StResp;
          wait_d  = '0;
        end
      end
      StResp: begin
        bus.MRespAccept = 1'b1;
        if (bus.SResp == Bus::DVA) begin
          fifo_wr = 1'b1;
          count_d = count_q + 16'd1;
          state_d = StIdle;
        end else if (bus.SResp == Bus::NULL) begin
          if (wait_q == WaitLast) begin
            err_d   = 1'b1;
            state_d = StErr;
          end else begin
            wait_d = wait_q + WaitW'(1);
          end
        end else begin
          err_d   = 1'b1;
          state_d = StErr;
        end
      end
      StErr: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  skid_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_valid_i (fifo_wr),
    .wr_data_i  (bus.SData),
    .full_o     (fifo_full),
    .rd_valid_o (out_valid),
    .rd_data_o  (out_data),
    .rd_ready_i (out_ready)
  );

endmodule

// File: tb/tb_msg_fetch_master.sv
// Directed bench for msg_fetch_master with a behavioural queue target on the bus.
module tb_msg_fetch_master;

  localparam int unsigned DW   = 32;
  localparam int unsigned ADDR = 32'h0000_0040;
  localparam int unsigned TO   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [15:0]   count;
  logic          timeout_err;

  Bus_if #(.DataWidth(DW)) bus ();

  msg_fetch_master #(
    .DATA_WIDTH   (DW),
    .ADDR_CHANNEL (ADDR),
    .RESP_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .enable      (enable),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Queue target: accepts RD when it holds a word, answers one cycle later.
  logic [DW-1:0] sq[$];
  logic [DW-1:0] got[$];
  logic          acc_rdy = 1'b0;
  bit            mute = 1'b0;
  bit            bad_resp = 1'b0;
  bit            resp_due = 1'b0;
  logic [DW-1:0] resp_word = '0;
  int            n_acc = 0;
  int            n_md_bad = 0;

  assign bus.SCmdAccept = (bus.MCmd == Bus::RD) && acc_rdy;

  always @(negedge clk or negedge bus.MReset_n) begin
    if (!bus.MReset_n) begin
      resp_due  = 1'b0;
      acc_rdy   = 1'b0;
      bus.SResp = Bus::NULL;
      bus.SData = '0;
    end else begin
      bus.SResp = Bus::NULL;
      if (resp_due) begin
        resp_due = 1'b0;
        if (bad_resp) begin
          bus.SResp = Bus::ERR;
        end else if (!mute) begin
          bus.SResp = Bus::DVA;
          bus.SData = resp_word;
        end
      end
      acc_rdy = (sq.size() != 0);
      if (bus.MCmd == Bus::RD && acc_rdy) begin
        resp_word = sq.pop_front();
        resp_due  = 1'b1;
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
    if (bus.MDataValid !== 1'b0 || bus.MData !== '0 || bus.MCmd == Bus::WR) n_md_bad++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) expire(name);
  endtask

  task automatic wait_resp_accept(input string name);
    int n = 0;
    while (bus.MRespAccept !== 1'b1 && n < 50) begin tick(); n++; end
    if (bus.MRespAccept !== 1'b1) expire(name);
  endtask

  task automatic wait_got(input int num, input string name);
    int n = 0;
    while (got.size() < num && n < 200) begin tick(); n++; end
    if (got.size() < num) expire(name);
  endtask

  task automatic reset_dut();
    sq.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    got.delete();
  endtask

  typedef struct {
    logic [31:0] word;
    logic [31:0] exp_data;
    logic [15:0] exp_count;
  } vec_t;

  vec_t          vecs[6];
  logic [DW-1:0] bp[5];
  int            acc0;
  int            n;
  int            nrd;

  initial begin
    vecs[0] = '{32'hA5A5_0001, 32'hA5A5_0001, 16'd1};
    vecs[1] = '{32'hA5A5_0002, 32'hA5A5_0002, 16'd2};
    vecs[2] = '{32'hA5A5_0003, 32'hA5A5_0003, 16'd3};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 16'd4};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd5};
    vecs[5] = '{32'h1234_5678, 32'h1234_5678, 16'd6};
    bp = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004, 32'hB000_0005};

    // Reset state
    repeat (3) tick();
    check("rst_mreset_n", bus.MReset_n, 1'b0);
    check("rst_mcmd", bus.MCmd, Bus::IDLE);
    check("rst_maddr", bus.MAddr, 32'h0);
    check("rst_mrespaccept", bus.MRespAccept, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_count", count, 16'h0);
    check("rst_timeout_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic fetch, one word at a time
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sq.push_back(vecs[i].word);
      wait_valid($sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), out_valid, 1'b0);
    end

    // Empty queue: RD held with no accept, and no timeout while in CMD
    repeat (4) tick();
    check("stall_mcmd", bus.MCmd, Bus::RD);
    check("stall_scmdaccept", bus.SCmdAccept, 1'b0);
    check("stall_maddr", bus.MAddr, ADDR);
    check("stall_mrespaccept", bus.MRespAccept, 1'b0);
    repeat (20) tick();
    check("stall_long_mcmd", bus.MCmd, Bus::RD);
    check("stall_long_timeout_err", timeout_err, 1'b0);

    // Backpressure: two reads fill the buffer, then everything drains in order
    got.delete();
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) sq.push_back(bp[i]);
    repeat (20) tick();
    check("bp_reads", n_acc - acc0, 2);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_head", out_data, bp[0]);
    check("bp_count", count, 16'd8);
    out_ready = 1'b1;
    wait_got(5, "bp_wait");
    for (int i = 0; i < 5; i++) check($sformatf("bp_word%0d", i), got[i], bp[i]);
    check("bp_count_end", count, 16'd11);
    repeat (5) tick();

    // Throughput: six words at one per three cycles
    got.delete();
    for (int i = 0; i < 6; i++) sq.push_back(32'hC000_0000 | i);
    n = 0;
    while (got.size() < 6 && n < 100) begin tick(); n++; end
    check("tput_cycles", n, 18);
    check("tput_last", got[5], 32'hC000_0005);

    // Simultaneous write and read with one entry buffered
    out_ready = 1'b0;
    got.delete();
    sq.push_back(32'hD0D0_0001);
    wait_valid("pp_wait1");
    sq.push_back(32'hD0D0_0002);
    wait_resp_accept("pp_resp");
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_valid", out_valid, 1'b1);
    check("pp_head", out_data, 32'hD0D0_0002);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pp_empty", out_valid, 1'b0);
    check("pp_got_n", got.size(), 2);
    check("pp_got0", got[0], 32'hD0D0_0001);
    check("pp_got1", got[1], 32'hD0D0_0002);

    // Enable dropped as CMD is entered on an empty queue
    enable = 1'b0;
    reset_dut();
    acc0 = n_acc;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (5) tick();
    check("edrop_held", bus.MCmd, Bus::RD);
    out_ready = 1'b1;
    sq.push_back(32'h0000_1234);
    wait_got(1, "edrop_wait");
    check("edrop_word", got[0], 32'h0000_1234);
    repeat (5) tick();
    check("edrop_idle", bus.MCmd, Bus::IDLE);
    check("edrop_reads", n_acc - acc0, 1);
    check("edrop_count", count, 16'd1);

    // Reset pulse while waiting in RESP with a word buffered
    out_ready = 1'b0;
    enable = 1'b1;
    sq.push_back(32'hE000_0001);
    wait_valid("rresp_wait");
    check("rresp_pre_count", count, 16'd2);
    mute = 1'b1;
    sq.push_back(32'hE000_0002);
    wait_resp_accept("rresp_accept");
    rst_n = 1'b0;
    #1;
    check("rresp_mcmd", bus.MCmd, Bus::IDLE);
    check("rresp_mrespaccept", bus.MRespAccept, 1'b0);
    check("rresp_count", count, 16'd0);
    check("rresp_out_valid", out_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    mute = 1'b0;
    got.delete();
    out_ready = 1'b1;
    sq.push_back(32'hE000_0003);
    wait_got(1, "rresp_resume");
    check("rresp_resume_word", got[0], 32'hE000_0003);
    check("rresp_resume_count", count, 16'd1);

    // Count wrap
    force dut.count_q = 16'hFFFF;
    tick();
    tick();
    release dut.count_q;
    check("wrap_pre", count, 16'hFFFF);
    got.delete();
    sq.push_back(32'hF00D_0001);
    wait_got(1, "wrap_wait");
    check("wrap_count", count, 16'h0000);

    // Response code other than NULL/DVA
    reset_dut();
    bad_resp = 1'b1;
    sq.push_back(32'h0BAD_0001);
    wait_resp_accept("bad_accept");
    tick();
    bad_resp = 1'b0;
    check("bad_err", timeout_err, 1'b1);
    check("bad_mcmd", bus.MCmd, Bus::IDLE);
    check("bad_count", count, 16'd0);

    // Response timeout, with a word already buffered
    reset_dut();
    out_ready = 1'b0;
    sq.push_back(32'h7700_0001);
    wait_valid("to_wait");
    mute = 1'b1;
    sq.push_back(32'h7700_0002);
    sq.push_back(32'h7700_0003);
    wait_resp_accept("to_accept");
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) check("to_err_cycle7", timeout_err, 1'b0);
      if (i == 8) check("to_err_cycle8", timeout_err, 1'b1);
    end
    acc0 = n_acc;
    nrd = 0;
    repeat (12) begin
      tick();
      if (bus.MCmd == Bus::RD) nrd++;
    end
    check("to_no_rd", nrd, 0);
    check("to_no_accept", n_acc - acc0, 0);
    check("to_drain_valid", out_valid, 1'b1);
    check("to_drain_head", out_data, 32'h7700_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("to_drained", out_valid, 1'b0);
    check("to_sticky", timeout_err, 1'b1);
    mute = 1'b0;

    check("mdata_idle", n_md_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected one");
    $fatal(1);
  end

endmodule
